upsample_2x_nn: RTL and testbench

//  Nearest-neighbour 2x upsampler for the decoder path, directly downstream of the max-pool/conv stages.

---
 rtl/upsample_2x_nn.sv | 252 +++++++++++++++++++++++++
 tb/tb_upsample_2x_nn.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/upsample_2x_nn.sv
// Nearest-neighbour 2x upsampler for the decoder path.
// Input lines of CHANNEL_NUM*STRING_LEN channel-interleaved samples are captured
// into one bank of a two-bank line RAM while the other bank plays back. Playback
// repeats every pixel twice and every line twice, producing 4x the samples.
//
// state  | meaning
// -------+----------------------------------------------------------------
// S_IDLE | no bank playing; start as soon as a bank holds a complete line
// S_PLAY | one read per cycle from play bank, 4*LINE_LEN cycles per line
module upsample_2x_nn #(
  parameter int DATA_WIDTH  = 8,
  parameter int CHANNEL_NUM = 3,
  parameter int STRING_LEN  = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         valid_i,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  input  logic                         sop_i,
  input  logic                         eop_i,
  input  logic                         sof_i,
  input  logic                         eof_i,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         data_valid_o,
  output logic                         sop_o,
  output logic                         eop_o,
  output logic                         sof_o,
  output logic                         eof_o,
  output logic                         overrun_o,
  output logic                         len_err_o
);

  localparam int LINE_LEN = CHANNEL_NUM * STRING_LEN;
  localparam int DEPTH    = 2 * LINE_LEN;
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Write counter must hold LINE_LEN+1 so over-long lines are still detected.
  localparam int CNTW     = $clog2(LINE_LEN + 2);
  localparam int CHW      = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
  localparam int PXW      = (STRING_LEN > 1) ? $clog2(STRING_LEN) : 1;

  typedef enum logic {S_IDLE, S_PLAY} state_t;

  // Line RAM, bank b occupies addresses b*LINE_LEN .. b*LINE_LEN+LINE_LEN-1.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Write side
  logic [CNTW-1:0] wr_cnt_q, wr_cnt_d, wr_idx;
  logic            wr_bank_q, wr_bank_d;
  logic            line_sof_q, line_sof_d, line_sof_now;
  logic [AW-1:0]   wr_addr;
  logic            wr_en, wr_busy, other_free, len_ok, line_done;
  logic            eop_ok, overrun_set, len_err_set;
  logic [1:0]      busy, free_now, mark_vec, pend_eff;
  logic [1:0]      tag_sof_q, tag_eof_q;
  logic            overrun_q, len_err_q;

  // Read side / FSM
  state_t          state_q, state_d;
  logic            play_bank_q, play_bank_d;
  logic [1:0]      pending_q, pending_d;
  logic [CHW-1:0]  ch_q;
  logic [PXW-1:0]  pix_q;
  logic            rep_pix_q, rep_line_q;
  logic            playing, last_read, start, start_bank;
  logic            rd_sop, rd_eop;
  logic [AW-1:0]   rd_addr;

  // First pipeline stage, aligned with rd_data_q
  logic            s1_valid_q, s1_sop_q, s1_eop_q, s1_sof_q, s1_eof_q;

  assign playing   = (state_q == S_PLAY);
  assign overrun_o = overrun_q;
  assign len_err_o = len_err_q;

  // Write-side decode: sample placement, line completion and bank hand-off.
  always_comb begin
    wr_idx = sop_i ? '0 : wr_cnt_q;

    // A bank is busy while it waits for playback or is being played.
    busy[0]     = pending_q[0] | (playing & ~play_bank_q);
    busy[1]     = pending_q[1] | (playing &  play_bank_q);
    // A bank finishing playback this very cycle already counts as free.
    free_now[0] = ~pending_q[0] & ~(playing & ~play_bank_q & ~last_read);
    free_now[1] = ~pending_q[1] & ~(playing &  play_bank_q & ~last_read);

    wr_busy    = busy[wr_bank_q];
    other_free = free_now[~wr_bank_q];

    len_ok      = (wr_idx == CNTW'(LINE_LEN - 1));
    line_done   = valid_i & eop_i;
    // Writes into a busy bank are suppressed so a queued line is never corrupted.
    wr_en       = valid_i & ~wr_busy & (wr_idx < CNTW'(LINE_LEN));
    eop_ok      = line_done & len_ok & ~wr_busy;
    overrun_set = line_done & len_ok &  wr_busy;
    len_err_set = line_done & ~len_ok;

    line_sof_now = sop_i ? sof_i : (line_sof_q | sof_i);

    mark_vec = eop_ok ? (wr_bank_q ? 2'b10 : 2'b01) : 2'b00;
    pend_eff = pending_q | mark_vec;

    wr_cnt_d   = wr_cnt_q;
    line_sof_d = line_sof_q;
    if (valid_i) begin
      if (eop_i) begin
        wr_cnt_d   = '0;
        line_sof_d = 1'b0;
      end else begin
        wr_cnt_d   = (wr_idx == CNTW'(LINE_LEN)) ? wr_idx : wr_idx + CNTW'(1);
        line_sof_d = line_sof_now;
      end
    end

    // Toggle on a completed line, or later between lines once a stuck
    // write bank (queued behind a playback) sees the other bank free up.
    wr_bank_d = wr_bank_q;
    if (eop_ok && other_free)
      wr_bank_d = ~wr_bank_q;
    else if (!valid_i && (wr_cnt_q == '0) && wr_busy && other_free)
      wr_bank_d = ~wr_bank_q;

    wr_addr = AW'(32'(wr_bank_q) * LINE_LEN + 32'(wr_idx));
  end

  // Line RAM write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= data_i;
  end

  // Registered RAM read port.
  always_ff @(posedge clk) begin
    rd_data_q <= mem_q[rd_addr];
  end

  // Write-side control registers, line tags and sticky error flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_cnt_q   <= '0;
      wr_bank_q  <= 1'b0;
      line_sof_q <= 1'b0;
      tag_sof_q  <= 2'b00;
      tag_eof_q  <= 2'b00;
      overrun_q  <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      wr_bank_q  <= wr_bank_d;
      line_sof_q <= line_sof_d;
      if (eop_ok) begin
        tag_sof_q[wr_bank_q] <= line_sof_now;
        tag_eof_q[wr_bank_q] <= eof_i;
      end
      if (overrun_set) overrun_q <= 1'b1;
      if (len_err_set) len_err_q <= 1'b1;
    end
  end

  // Playback sequencing: bank selection, read address and position flags.
  always_comb begin
    last_read = playing && (ch_q == CHW'(CHANNEL_NUM - 1)) &&
                (pix_q == PXW'(STRING_LEN - 1)) && rep_pix_q && rep_line_q;

    // The bank not played last is always the older one when both are queued.
    start      = 1'b0;
    start_bank = play_bank_q;
    if (!playing || last_read) begin
      if (pend_eff[~play_bank_q]) begin
        start      = 1'b1;
        start_bank = ~play_bank_q;
      end else if (pend_eff[play_bank_q]) begin
        start      = 1'b1;
        start_bank = play_bank_q;
      end
    end

    state_d     = start ? S_PLAY : (last_read ? S_IDLE : state_q);
    play_bank_d = start ? start_bank : play_bank_q;
    pending_d   = pend_eff & ~(start ? (start_bank ? 2'b10 : 2'b01) : 2'b00);

    rd_sop = (ch_q == '0) && (pix_q == '0) && !rep_pix_q;
    rd_eop = (ch_q == CHW'(CHANNEL_NUM - 1)) && (pix_q == PXW'(STRING_LEN - 1)) && rep_pix_q;

    rd_addr = AW'(32'(play_bank_q) * LINE_LEN + 32'(pix_q) * CHANNEL_NUM + 32'(ch_q));
  end

  // Playback FSM: state, nested read counters and the stage-1 flag register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      play_bank_q <= 1'b0;
      pending_q   <= 2'b00;
      ch_q        <= '0;
      pix_q       <= '0;
      rep_pix_q   <= 1'b0;
      rep_line_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_sop_q    <= 1'b0;
      s1_eop_q    <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_eof_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      play_bank_q <= play_bank_d;
      pending_q   <= pending_d;

      // Counters wrap to zero on the last read, ready for a back-to-back line.
      if (playing) begin
        if (ch_q == CHW'(CHANNEL_NUM - 1)) begin
          ch_q      <= '0;
          rep_pix_q <= ~rep_pix_q;
          if (rep_pix_q) begin
            if (pix_q == PXW'(STRING_LEN - 1)) begin
              pix_q      <= '0;
              rep_line_q <= ~rep_line_q;
            end else begin
              pix_q <= pix_q + PXW'(1);
            end
          end
        end else begin
          ch_q <= ch_q + CHW'(1);
        end
      end

      s1_valid_q <= playing;
      s1_sop_q   <= playing & rd_sop;
      s1_eop_q   <= playing & rd_eop;
      s1_sof_q   <= playing & rd_sop & ~rep_line_q & tag_sof_q[play_bank_q];
      s1_eof_q   <= last_read & tag_eof_q[play_bank_q];
    end
  end

  // Output register; data is forced to zero whenever no sample is presented.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_o       <= '0;
      data_valid_o <= 1'b0;
      sop_o        <= 1'b0;
      eop_o        <= 1'b0;
      sof_o        <= 1'b0;
      eof_o        <= 1'b0;
    end else begin
      data_o       <= s1_valid_q ? rd_data_q : '0;
      data_valid_o <= s1_valid_q;
      sop_o        <= s1_sop_q;
      eop_o        <= s1_eop_q;
      sof_o        <= s1_sof_q;
      eof_o        <= s1_eof_q;
    end
  end

endmodule

// File: tb/tb_upsample_2x_nn.sv
// Testbench for upsample_2x_nn (DATA_WIDTH=8, CHANNEL_NUM=3, STRING_LEN=4).
// Expected output samples are queued when a line is driven and popped as the
// DUT presents them; timing, run lengths and sticky flags are checked directly.
module tb_upsample_2x_nn;

  localparam int C  = 3;
  localparam int S  = 4;
  localparam int LL = C * S;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              valid_i, sop_i, eop_i, sof_i, eof_i;
  logic signed [7:0] data_i;
  logic signed [7:0] data_o;
  logic              data_valid_o, sop_o, eop_o, sof_o, eof_o, overrun_o, len_err_o;

  upsample_2x_nn #(.DATA_WIDTH(8), .CHANNEL_NUM(C), .STRING_LEN(S)) dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .data_i(data_i),
    .sop_i(sop_i), .eop_i(eop_i), .sof_i(sof_i), .eof_i(eof_i),
    .data_o(data_o), .data_valid_o(data_valid_o), .sop_o(sop_o), .eop_o(eop_o),
    .sof_o(sof_o), .eof_o(eof_o), .overrun_o(overrun_o), .len_err_o(len_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [7:0] data;
    logic              sop, eop, sof, eof;
  } exp_t;

  typedef struct {
    int base;
    int nsamp;
    bit sof;
    bit eof;
    int gap;
    bit exp_out;
    bit exp_lerr;
  } line_vec_t;

  exp_t      sb_q[$];
  line_vec_t vecs[8];

  int tests = 0, fails = 0;
  int cyc = 0, run = 0, last_run = 0, max_run = 0, rise_cyc = -1, pop_cnt = 0;
  int last_eop_cyc = 0;
  bit prev_v = 1'b0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // One clock: sample outputs on the falling edge, then let the DUT take inputs.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (data_valid_o) begin
      if (!prev_v) rise_cyc = cyc;
      run++;
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got data=%0d at cycle %0d, expected no output", data_o, cyc);
      end else begin
        e = sb_q.pop_front();
        if (data_o !== e.data || sop_o !== e.sop || eop_o !== e.eop ||
            sof_o !== e.sof || eof_o !== e.eof) begin
          fails++;
          $display("FAIL scoreboard #%0d: got data=%0d sop=%0b eop=%0b sof=%0b eof=%0b, expected data=%0d sop=%0b eop=%0b sof=%0b eof=%0b",
                   pop_cnt, data_o, sop_o, eop_o, sof_o, eof_o, e.data, e.sop, e.eop, e.sof, e.eof);
        end
        pop_cnt++;
      end
    end else if (prev_v) begin
      last_run = run;
      if (run > max_run) max_run = run;
      run = 0;
    end
    prev_v = data_valid_o;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
    repeat (n) step();
  endtask

  // Pixel p, channel c carries base+10*p+c; optionally queue the 48 expected outputs.
  task automatic drive_line(input int base, input int nsamp, input bit sof, input bit eof, input bit push);
    exp_t e;
    if (push) begin
      for (int rl = 0; rl < 2; rl++)
        for (int p = 0; p < S; p++)
          for (int rp = 0; rp < 2; rp++)
            for (int c = 0; c < C; c++) begin
              e.data = 8'(base + 10 * p + c);
              e.sop  = (p == 0) && (rp == 0) && (c == 0);
              e.eop  = (p == S - 1) && (rp == 1) && (c == C - 1);
              e.sof  = e.sop && (rl == 0) && sof;
              e.eof  = e.eop && (rl == 1) && eof;
              sb_q.push_back(e);
            end
    end
    for (int i = 0; i < nsamp; i++) begin
      valid_i = 1'b1;
      data_i  = 8'(base + 10 * (i / C) + (i % C));
      sop_i   = (i == 0);
      eop_i   = (i == nsamp - 1);
      sof_i   = sof && (i == 0);
      eof_i   = eof && (i == nsamp - 1);
      step();
    end
    last_eop_cyc = cyc;
    idle(0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      step();
      n++;
    end
    check({name, "_outputs_left"}, sb_q.size(), 0);
    idle(4);
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    idle(n);
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{5,    12, 1'b1, 1'b0, 36, 1'b1, 1'b0};
    vecs[1] = '{50,   12, 1'b0, 1'b1, 36, 1'b1, 1'b0};
    vecs[2] = '{-60,  12, 1'b1, 1'b0, 36, 1'b1, 1'b0};
    vecs[3] = '{7,    12, 1'b0, 1'b1, 36, 1'b1, 1'b0};
    vecs[4] = '{90,   12, 1'b1, 1'b0, 36, 1'b1, 1'b0};
    vecs[5] = '{-128, 12, 1'b0, 1'b1, 36, 1'b1, 1'b0};
    vecs[6] = '{33,   11, 1'b0, 1'b0, 37, 1'b0, 1'b1};
    vecs[7] = '{-20,  12, 1'b1, 1'b1, 0,  1'b1, 1'b1};

    reset_n = 1'b0;
    data_i  = '0;
    idle(3);
    check("rst_data_o",       data_o,       0);
    check("rst_data_valid_o", data_valid_o, 0);
    check("rst_sop_o",        sop_o,        0);
    check("rst_eop_o",        eop_o,        0);
    check("rst_sof_o",        sof_o,        0);
    check("rst_eof_o",        eof_o,        0);
    check("rst_overrun_o",    overrun_o,    0);
    check("rst_len_err_o",    len_err_o,    0);
    reset_n = 1'b1;

    // Single line, eop at cycle 100, valid expected from 103 for 48 cycles.
    while (cyc < 88) step();
    drive_line(0, LL, 1'b1, 1'b1, 1'b1);
    drain("t1");
    check("t1_first_valid_cycle", rise_cyc, last_eop_cyc + 3);
    check("t1_valid_run", last_run, 48);
    check("t1_overrun", overrun_o, 0);
    check("t1_len_err", len_err_o, 0);

    // Three frames of two lines at 48-cycle spacing, a short line, then a good line.
    max_run = 0;
    for (int k = 0; k < 8; k++) begin
      drive_line(vecs[k].base, vecs[k].nsamp, vecs[k].sof, vecs[k].eof, vecs[k].exp_out);
      check($sformatf("t2_len_err_row%0d", k), len_err_o, int'(vecs[k].exp_lerr));
      check($sformatf("t2_overrun_row%0d", k), overrun_o, 0);
      idle(vecs[k].gap);
    end
    drain("t2");
    check("t2_longest_valid_run", max_run, 288);

    // Three back-to-back lines: the third is dropped.
    do_reset(2);
    check("t3_overrun_after_reset", overrun_o, 0);
    check("t3_len_err_after_reset", len_err_o, 0);
    max_run = 0;
    drive_line(1,  LL, 1'b1, 1'b0, 1'b1);
    drive_line(41, LL, 1'b0, 1'b0, 1'b1);
    drive_line(81, LL, 1'b0, 1'b1, 1'b0);
    check("t3_overrun", overrun_o, 1);
    check("t3_len_err", len_err_o, 0);
    drain("t3");
    check("t3_longest_valid_run", max_run, 96);

    // Reset held low for the cycle showing output 20 of a playback.
    do_reset(2);
    pop_cnt = 0;
    drive_line(-100, LL, 1'b1, 1'b1, 1'b1);
    n = 0;
    while (pop_cnt < 20 && n < 200) begin
      step();
      n++;
    end
    check("t4_outputs_before_reset", pop_cnt, 20);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("t4_rst_data_o",       data_o,       0);
    check("t4_rst_data_valid_o", data_valid_o, 0);
    check("t4_rst_sop_o",        sop_o,        0);
    check("t4_rst_eop_o",        eop_o,        0);
    check("t4_rst_sof_o",        sof_o,        0);
    check("t4_rst_eof_o",        eof_o,        0);
    sb_q.delete();
    idle(10);
    drive_line(3, LL, 1'b1, 1'b1, 1'b1);
    drain("t4");
    check("t4_first_valid_cycle", rise_cyc, last_eop_cyc + 3);
    check("t4_valid_run", last_run, 48);
    check("t4_overrun", overrun_o, 0);
    check("t4_len_err", len_err_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
